// File: rtl/ahb_mtx_decoder_np.sv
// AHB bus-matrix input-stage decoder with mask/base regions and a built-in error-responding default slave.
// Optional AHB_MTX_DECODER_REMAP_EN adds a remap input that swaps the regions of ports 0 and 1.
//
// Default-slave FSM:
//   state   | meaning
//   DS_IDLE | zero-wait OKAY, waiting for an unmapped NONSEQ/SEQ
//   DS_ERR1 | first ERROR cycle, HREADYOUT low
//   DS_ERR2 | second ERROR cycle, HREADYOUT high, unmapped_err pulse
module ahb_mtx_decoder_np #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter logic [NUM_PORTS*22-1:0] PORT_BASE = {22'h000000, 22'h080000, 22'h100000, 22'h140000},
    parameter logic [NUM_PORTS*22-1:0] PORT_MASK = {22'h380000, 22'h380000, 22'h3C0000, 22'h3C0000},
    parameter int PW        = $clog2(NUM_PORTS + 1)
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        HREADYS,
    input  logic                        sel_dec,
    input  logic [21:0]                 decode_addr_dec,
    input  logic [1:0]                  trans_dec,
`ifdef AHB_MTX_DECODER_REMAP_EN
    input  logic                        remap,
`endif
    input  logic [NUM_PORTS-1:0]        active_dec_i,
    input  logic [NUM_PORTS-1:0]        readyout_dec_i,
    input  logic [2*NUM_PORTS-1:0]      resp_dec_i,
    input  logic [DATA_W*NUM_PORTS-1:0] rdata_dec_i,
    input  logic [DATA_W*NUM_PORTS-1:0] ruser_dec_i,
    output logic [NUM_PORTS-1:0]        sel_dec_o,
    output logic                        active_dec,
    output logic                        HREADYOUTS,
    output logic [1:0]                  HRESPS,
    output logic [DATA_W-1:0]           HRDATAS,
    output logic [DATA_W-1:0]           HRUSERS,
    output logic                        unmapped_err
);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    localparam logic [PW-1:0] DEF_PORT = PW'(NUM_PORTS);
    localparam int            P1       = (NUM_PORTS > 1) ? 1 : 0;

    logic [21:0]          region_base [NUM_PORTS];
    logic [21:0]          region_mask [NUM_PORTS];
    logic [NUM_PORTS-1:0] hit;
    logic [PW-1:0]        addr_port;
    logic [PW-1:0]        data_port;
    ds_state_t            ds_state;
    ds_state_t            ds_next;
    logic                 ds_take;
    logic                 ds_readyout;
    logic [1:0]           ds_resp;

    // Port 0 is the first (most significant) entry of the packed region parameters.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_region
        assign region_base[g] = PORT_BASE[(NUM_PORTS-1-g)*22 +: 22];
        assign region_mask[g] = PORT_MASK[(NUM_PORTS-1-g)*22 +: 22];
    end

    always_comb begin : hit_calc
        int r;
        r   = 0;
        hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef AHB_MTX_DECODER_REMAP_EN
            r = (remap && i == 0) ? P1 : ((remap && i == P1) ? 0 : i);
`else
            r = i;
`endif
            hit[i] = (decode_addr_dec & region_mask[r]) == region_base[r];
        end
    end

    // IDLE keeps the current data-phase port selected so the switch does not toggle needlessly.
    always_comb begin
        addr_port = DEF_PORT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (hit[i]) addr_port = PW'(i);
        end
        if (trans_dec == 2'b00 && data_port != DEF_PORT) addr_port = data_port;
    end

    always_comb begin
        sel_dec_o  = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port == PW'(i)) begin
                sel_dec_o[i] = sel_dec;
                active_dec   = active_dec_i[i];
            end
        end
    end

    assign ds_take = HREADYS & sel_dec & (addr_port == DEF_PORT) & trans_dec[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state  <= DS_IDLE;
            data_port <= '0;
        end else begin
            ds_state <= ds_next;
            if (HREADYS) data_port <= addr_port;
        end
    end

    always_comb begin
        ds_next      = ds_state;
        ds_readyout  = 1'b1;
        ds_resp      = 2'b00;
        unmapped_err = 1'b0;
        case (ds_state)
            DS_IDLE: begin
                if (ds_take) ds_next = DS_ERR1;
            end
            DS_ERR1: begin
                ds_readyout = 1'b0;
                ds_resp     = 2'b01;
                ds_next     = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp      = 2'b01;
                unmapped_err = 1'b1;
                ds_next      = ds_take ? DS_ERR1 : DS_IDLE;
            end
            default: ds_next = DS_IDLE;
        endcase
    end

    // Codes above NUM_PORTS cannot be reached; leave them undefined.
    always_comb begin
        HREADYOUTS = 1'bx;
        HRESPS     = 'x;
        HRDATAS    = 'x;
        HRUSERS    = 'x;
        if (data_port == DEF_PORT) begin
            HREADYOUTS = ds_readyout;
            HRESPS     = ds_resp;
            HRDATAS    = '0;
            HRUSERS    = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port == PW'(i)) begin
                HREADYOUTS = readyout_dec_i[i];
                HRESPS     = resp_dec_i[2*i +: 2];
                HRDATAS    = rdata_dec_i[DATA_W*i +: DATA_W];
                HRUSERS    = ruser_dec_i[DATA_W*i +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_ahb_mtx_decoder_np.sv
// Scoreboard bench for ahb_mtx_decoder_np: directed vectors push expectations, a negedge monitor checks them.
module tb_ahb_mtx_decoder_np;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic             HREADYS = 1'b1;
    logic             sel_dec = 1'b0;
    logic [21:0]      decode_addr_dec = '0;
    logic [1:0]       trans_dec = T_IDLE;
    logic [NP-1:0]    active_dec_i = 4'b1001;
    logic [NP-1:0]    readyout_dec_i = 4'hF;
    logic [2*NP-1:0]  resp_dec_i;
    logic [DW*NP-1:0] rdata_dec_i;
    logic [DW*NP-1:0] ruser_dec_i;
    logic [NP-1:0]    sel_dec_o;
    logic             active_dec;
    logic             HREADYOUTS;
    logic [1:0]       HRESPS;
    logic [DW-1:0]    HRDATAS;
    logic [DW-1:0]    HRUSERS;
    logic             unmapped_err;
`ifdef AHB_MTX_DECODER_REMAP_EN
    logic             remap = 1'b0;
    logic             remap_next = 1'b0;
    localparam bit    REMAP_ON = 1'b1;
`else
    localparam bit    REMAP_ON = 1'b0;
`endif

    logic [DW-1:0] rd_t [NP];
    logic [DW-1:0] ru_t [NP];
    logic [1:0]    rs_t [NP];

    typedef struct packed {
        logic [NP-1:0] sel;
        logic          act;
        logic          rdy;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
        logic [DW-1:0] ruser;
        logic          uerr;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    total = 0;
    int    bad = 0;

    ahb_mtx_decoder_np dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
`ifdef AHB_MTX_DECODER_REMAP_EN
        .remap           (remap),
`endif
        .active_dec_i    (active_dec_i),
        .readyout_dec_i  (readyout_dec_i),
        .resp_dec_i      (resp_dec_i),
        .rdata_dec_i     (rdata_dec_i),
        .ruser_dec_i     (ruser_dec_i),
        .sel_dec_o       (sel_dec_o),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS),
        .HRUSERS         (HRUSERS),
        .unmapped_err    (unmapped_err)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        rd_t[0] = 32'hDEADBEEF; rd_t[1] = 32'h11111111; rd_t[2] = 32'h22222222; rd_t[3] = 32'h33333333;
        ru_t[0] = 32'h000000A0; ru_t[1] = 32'h000000A1; ru_t[2] = 32'h000000A2; ru_t[3] = 32'h000000A3;
        rs_t[0] = 2'b00; rs_t[1] = 2'b00; rs_t[2] = 2'b10; rs_t[3] = 2'b11;
        for (int i = 0; i < NP; i++) begin
            rdata_dec_i[DW*i +: DW] = rd_t[i];
            ruser_dec_i[DW*i +: DW] = ru_t[i];
            resp_dec_i[2*i +: 2]    = rs_t[i];
        end
    end

    // p selects the expected data-phase source: 0..NP-1 a port, NP the default slave.
    task automatic step(input string nm, input logic rs, input logic s, input logic [31:0] a,
                        input logic [1:0] t, input logic [NP-1:0] rdy_in, input logic [NP-1:0] esel,
                        input logic eact, input logic erdy, input logic [1:0] eresp, input int p,
                        input logic euerr);
        exp_t e;
        @(posedge HCLK);
        #1;
`ifdef AHB_MTX_DECODER_REMAP_EN
        remap = remap_next;
`endif
        HREADYS         = rs;
        sel_dec         = s;
        decode_addr_dec = a[31:10];
        trans_dec       = t;
        readyout_dec_i  = rdy_in;
        e.sel   = esel;
        e.act   = eact;
        e.rdy   = erdy;
        e.resp  = eresp;
        e.uerr  = euerr;
        e.rdata = '0;
        e.ruser = '0;
        if (p < NP) begin
            e.rdata = rd_t[p];
            e.ruser = ru_t[p];
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS, unmapped_err};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got sel=%b act=%b rdy=%b resp=%b rdata=%h ruser=%h uerr=%b, want sel=%b act=%b rdy=%b resp=%b rdata=%h ruser=%h uerr=%b",
                             nm, got.sel, got.act, got.rdy, got.resp, got.rdata, got.ruser, got.uerr,
                             e.sel, e.act, e.rdy, e.resp, e.rdata, e.ruser, e.uerr);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int dp_remap;
        dp_remap = REMAP_ON ? 1 : 0;
        //   name            rdys sel addr          trans   rdy   esel     act rdy resp  p  uerr
        step("reset",         1,  0, 32'h0,        T_IDLE, 4'hF, 4'b0000, 1, 1, 2'b00, 0, 0);
        HRESETn = 1'b1;
        step("p0_addr",       1,  1, 32'h00001000, T_NSEQ, 4'hF, 4'b0001, 1, 1, 2'b00, 0, 0);
        step("p0_data",       1,  1, 32'h20000000, T_NSEQ, 4'hF, 4'b0010, 0, 1, 2'b00, 0, 0);
        step("p1_wait1",      0,  1, 32'h40000000, T_NSEQ, 4'hD, 4'b0100, 0, 0, 2'b00, 1, 0);
        step("p1_wait2",      0,  1, 32'h40000000, T_NSEQ, 4'hD, 4'b0100, 0, 0, 2'b00, 1, 0);
        step("p1_done",       1,  1, 32'h40000000, T_NSEQ, 4'hF, 4'b0100, 0, 1, 2'b00, 1, 0);
        step("unmap_addr",    1,  1, 32'hF0000000, T_NSEQ, 4'hF, 4'b0000, 1, 1, 2'b10, 2, 0);
        step("unmap_err1",    0,  0, 32'h0,        T_IDLE, 4'hF, 4'b0000, 1, 0, 2'b01, NP, 0);
        step("unmap_err2",    1,  0, 32'h0,        T_IDLE, 4'hF, 4'b0000, 1, 1, 2'b01, NP, 1);
        step("b2b_addr",      1,  1, 32'hF0000000, T_NSEQ, 4'hF, 4'b0000, 1, 1, 2'b00, 0, 0);
        step("b2b_err1a",     0,  1, 32'hF0000000, T_NSEQ, 4'hF, 4'b0000, 1, 0, 2'b01, NP, 0);
        step("b2b_err2a",     1,  1, 32'hF0000000, T_SEQ,  4'hF, 4'b0000, 1, 1, 2'b01, NP, 1);
        step("b2b_err1b",     0,  1, 32'hF0000000, T_IDLE, 4'hF, 4'b0000, 1, 0, 2'b01, NP, 0);
        step("b2b_err2b",     1,  1, 32'hF0000000, T_IDLE, 4'hF, 4'b0000, 1, 1, 2'b01, NP, 1);
        step("idle_unmap",    1,  1, 32'hF0000000, T_IDLE, 4'hF, 4'b0000, 1, 1, 2'b00, NP, 0);
        step("p2_addr",       1,  1, 32'h40000000, T_NSEQ, 4'hF, 4'b0100, 0, 1, 2'b00, NP, 0);
        step("hold_p2",       1,  1, 32'hF0000000, T_IDLE, 4'hF, 4'b0100, 0, 1, 2'b10, 2, 0);
        step("p3_addr",       1,  1, 32'h50000000, T_NSEQ, 4'hF, 4'b1000, 1, 1, 2'b10, 2, 0);
        step("hold_p3",       1,  0, 32'h0,        T_IDLE, 4'hF, 4'b0000, 1, 1, 2'b11, 3, 0);
        step("rst_err_addr",  1,  1, 32'hF0000000, T_NSEQ, 4'hF, 4'b0000, 1, 1, 2'b11, 3, 0);
        step("rst_err_e1",    0,  0, 32'h0,        T_IDLE, 4'hF, 4'b0000, 1, 0, 2'b01, NP, 0);
        @(negedge HCLK);
        #1 HRESETn = 1'b0;
        step("rst_in_err",    1,  0, 32'h0,        T_IDLE, 4'hF, 4'b0000, 1, 1, 2'b00, 0, 0);
        @(negedge HCLK);
        #1 HRESETn = 1'b1;
`ifdef AHB_MTX_DECODER_REMAP_EN
        remap_next = 1'b1;
        step("remap_addr",    1,  1, 32'h0,        T_NSEQ, 4'hF, 4'b0010, 0, 1, 2'b00, 0, 0);
        remap_next = 1'b0;
`else
        step("fixed_addr",    1,  1, 32'h0,        T_NSEQ, 4'hF, 4'b0001, 1, 1, 2'b00, 0, 0);
`endif
        step("busy_unmap",    1,  1, 32'hF0000000, T_BUSY, 4'hF, 4'b0000, 1, 1, 2'b00, dp_remap, 0);
        step("busy_okay",     1,  0, 32'h0,        T_IDLE, 4'hF, 4'b0000, 1, 1, 2'b00, NP, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge HCLK);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_decoder_np.md
Name: ahb_mtx_decoder_np

Overview:
- Parametrised AHB bus-matrix input-stage decoder with NUM_PORTS output ports and mask/base address regions.
- Has an integrated error-responding default slave with a two-cycle ERROR FSM.
- Sits between the matrix input stage and the per-output-port bus switches.
- Routes address-phase selects; muxes data-phase HREADYOUT/HRESP/HRDATA/HRUSER from the port registered at the last HREADYS.

Parameters:
- NUM_PORTS, 4, number of output ports (1..8).
- DATA_W, 32, HRDATA/HRUSER width.
- PORT_BASE, {22'h000000,22'h080000,22'h100000,22'h140000}, packed NUM_PORTS*22 region base, compared against decode_addr_dec[31:10].
- PORT_MASK, {22'h380000,22'h380000,22'h3C0000,22'h3C0000}, packed NUM_PORTS*22 region mask.
- PW, $clog2(NUM_PORTS+1), port index width. Value NUM_PORTS denotes the default slave.

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  asynchronous active-low reset
- HREADYS  in  1  transfer-done from input stage
- sel_dec  in  1  HSEL from input stage
- decode_addr_dec  in  22  HADDR[31:10]
- trans_dec  in  2  HTRANS
- active_dec_i  in  NUM_PORTS  per-port output-stage active
- readyout_dec_i  in  NUM_PORTS  per-port HREADYOUT
- resp_dec_i  in  2*NUM_PORTS  per-port HRESP
- rdata_dec_i  in  DATA_W*NUM_PORTS  per-port HRDATA
- ruser_dec_i  in  DATA_W*NUM_PORTS  per-port HRUSER
- sel_dec_o  out  NUM_PORTS  per-port HSEL
- active_dec  out  1  selected active
- HREADYOUTS  out  1  selected HREADYOUT
- HRESPS  out  2  selected HRESP
- HRDATAS  out  DATA_W  selected read data
- HRUSERS  out  DATA_W  selected read user data
- unmapped_err  out  1  one-cycle pulse when the default slave issues the second ERROR cycle

Behaviour:
- Reset HRESETn (asynchronous, active-low), clock HCLK.
- Region hit i: (decode_addr_dec & PORT_MASK[i]) == PORT_BASE[i]. The lowest index hit wins.
- Address-port selection:
  - addr_port = lowest hit.
  - Hold case: if trans_dec==IDLE and data_port!=NUM_PORTS, addr_port = data_port. This avoids spurious port switching on IDLE.
  - No hit otherwise: addr_port = NUM_PORTS.
- sel_dec_o[addr_port] = sel_dec; all other bits 0. Default-slave select is internal only.
- active_dec = active_dec_i[addr_port]; 1 when addr_port==NUM_PORTS.
- data_port register:
  - Reset 0.
  - Loads addr_port when HREADYS=1; holds otherwise.
- Data-phase mux by data_port:
  - Port i: HREADYOUTS/HRESPS/HRDATAS/HRUSERS = port i inputs.
  - Default slave: FSM outputs; HRDATAS = HRUSERS = 0.
- Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2. Reset DS_IDLE.
  - DS_IDLE: HREADYOUT=1, HRESP=OKAY. Goes to DS_ERR1 when HREADYS & sel_dec & addr_port==NUM_PORTS & trans_dec[1]=1 (NONSEQ/SEQ). IDLE/BUSY get zero-wait OKAY.
  - DS_ERR1: HREADYOUT=0, HRESP=ERROR. Unconditionally goes to DS_ERR2.
  - DS_ERR2: HREADYOUT=1, HRESP=ERROR, unmapped_err=1. Goes to DS_ERR1 if a new qualifying unmapped transfer is sampled, else DS_IDLE.
- Reset values: sel_dec_o=0 (while sel_dec=0), HREADYOUTS=readyout_dec_i[0], unmapped_err=0, FSM DS_IDLE.
- Latency: select is combinational same-cycle; data-phase mux is one registered stage behind the address phase.
- Reset asserted mid-ERROR: FSM returns to DS_IDLE and data_port to 0 immediately.
- Unreachable data_port codes (>NUM_PORTS): outputs X in simulation.
- NUM_PORTS=1 must elaborate; PW>=1.

Optional Feature:
- Macro: AHB_MTX_DECODER_REMAP_EN.
- Defined: adds input port remap (1 bit). When remap=1, the address regions of port 0 and port 1 are swapped in the hit computation. remap is sampled combinationally; software changes it only while the bus is idle.
- Undefined: no remap port; fixed mapping.

Test Plan:
- Reset, then NONSEQ to 0x0000_1000 with sel_dec=1 -> sel_dec_o=4'b0001; next cycle HRDATAS = rdata_dec_i slice 0 (drive 0xDEADBEEF).
- NONSEQ to 0x2000_0000 (port 1), port 1 holds readyout=0 for 2 cycles -> HREADYOUTS low for 2 cycles; data_port unchanged until HREADYS=1.
- NONSEQ to 0xF000_0000 (unmapped) -> sel_dec_o=0; data-phase HREADYOUTS 0 then 1 with HRESPS=2'b01 both cycles; unmapped_err pulses in the 2nd cycle; HRDATAS=0.
- Back-to-back unmapped NONSEQ sampled in DS_ERR2 -> sequence DS_ERR1, DS_ERR2, DS_ERR1, DS_ERR2; then IDLE to 0xF000_0000 -> zero-wait OKAY.
- IDLE to an unmapped address while data_port=2 -> sel_dec_o=4'b0100, active_dec = active_dec_i[2].
- With AHB_MTX_DECODER_REMAP_EN and remap=1, NONSEQ to 0x0000_0000 -> sel_dec_o=4'b0010. HRESETn asserted during DS_ERR1 -> HRESPS=OKAY on the next evaluated cycle.
